// File: rtl/bcd_scan_driver.sv
// rtl/bcd_scan_driver.sv - binary to packed BCD converter with round-robin digit scanner
module bcd_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 1000,
  parameter bit LZB      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BIN_W-1:0]  bin_in,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        bcd_out,
  output logic              blank_out,
  output logic [DIGITS-1:0] dig_sel
);

  localparam int BCD_W  = DIGITS * 4;
  localparam int SR_W   = BCD_W + BIN_W;
  localparam int STEP_W = $clog2(BIN_W + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Smallest value that no longer fits in DIGITS decimal digits.
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  // Display pattern shown when the loaded value is too large.
  function automatic logic [BCD_W-1:0] all_nines();
    logic [BCD_W-1:0] v;
    v = '0;
    for (int d = 0; d < DIGITS; d++) begin
      v[4*d +: 4] = 4'd9;
    end
    return v;
  endfunction

  // One double-dabble iteration: correct every BCD nibble, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[BIN_W + 4*d +: 4] >= 4'd5) begin
        t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  localparam logic [31:0]      OVF_LIMIT = pow10(DIGITS);
  localparam logic [BCD_W-1:0] NINES     = all_nines();

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                ovf_q, ovf_d;
  logic [BCD_W-1:0]    disp_q, disp_d;
  logic                valid_q, valid_d;

  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic [3:0]          bcd_q, bcd_d;
  logic                blank_q, blank_d;
  logic                scan_wrap;
  logic                any_nonzero;

  // Conversion FSM: capture on load, shift BIN_W times, commit to the display.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    step_d  = step_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d    = {{BCD_W{1'b0}}, bin_in};
          ovf_d   = (32'(bin_in) >= OVF_LIMIT);
          step_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d   = dabble_step(sr_q);
        step_d = step_q + 1'b1;
        if (step_q == STEP_W'(BIN_W - 1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        disp_d  = ovf_q ? NINES : sr_q[SR_W-1 -: BCD_W];
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Conversion state registers; reset aborts any conversion and clears the display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      step_q  <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      step_q  <= step_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      valid_q <= valid_d;
    end
  end

  // Scanner: next slot index plus the nibble, blank flag and select for that slot.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    any_nonzero = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx_d)) && (disp_q[4*j +: 4] != 4'd0)) begin
        any_nonzero = 1'b1;
      end
    end
    dig_sel_d = DIGITS'(1) << idx_d;
    bcd_d     = disp_q[{idx_d, 2'b00} +: 4];
    blank_d   = !valid_q || (LZB && (idx_d != '0) && !any_nonzero);
  end

  // Free-running scan registers; all three outputs switch on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      dig_sel_q  <= DIGITS'(1);
      bcd_q      <= 4'd0;
      blank_q    <= 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      dig_sel_q  <= dig_sel_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign ovf       = ovf_q;
  assign bcd_out   = bcd_q;
  assign blank_out = blank_q;
  assign dig_sel   = dig_sel_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb/tb_bcd_scan_driver.sv - self-checking bench for bcd_scan_driver
module tb_bcd_scan_driver;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam bit LZB      = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic              busy;
  logic              ovf;
  logic [3:0]        bcd_out;
  logic              blank_out;
  logic [DIGITS-1:0] dig_sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bcd_scan_driver #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .LZB(LZB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bin_in(bin_in),
    .busy(busy), .ovf(ovf), .bcd_out(bcd_out), .blank_out(blank_out),
    .dig_sel(dig_sel)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int p10(input int n);
    int p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  // Reference model: decimal value on display, busy countdown, scan slot from cycle count.
  int m_cyc, m_busy_left, m_pend_val, m_val, m_idx;
  bit m_pend_ovf, m_ovf, m_valid, m_armed;
  int e_bcd;
  bit e_blank;
  initial begin
    m_armed = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_armed = 1; m_cyc = 0; m_busy_left = 0; m_val = 0;
        m_valid = 0; m_ovf = 0; e_bcd = 0; e_blank = 1;
      end else if (m_armed) begin
        m_cyc++;
        m_idx   = (m_cyc / SCAN_DIV) % DIGITS;
        e_bcd   = (m_val / p10(m_idx)) % 10;
        e_blank = !m_valid || (m_idx > 0 && m_val < p10(m_idx));
        if (m_busy_left > 0) begin
          m_busy_left--;
          if (m_busy_left == 0) begin
            m_val   = m_pend_ovf ? p10(DIGITS) - 1 : m_pend_val;
            m_valid = 1;
          end
        end else if (load) begin
          m_busy_left = BIN_W + 1;
          m_pend_val  = int'(bin_in);
          m_pend_ovf  = (int'(bin_in) >= p10(DIGITS));
          m_ovf       = m_pend_ovf;
        end
      end
      if (m_armed) begin
        m_idx = (m_cyc / SCAN_DIV) % DIGITS;
        check("m_busy",    int'(busy),      int'(m_busy_left > 0));
        check("m_ovf",     int'(ovf),       int'(m_ovf));
        check("m_dig_sel", int'(dig_sel),   1 << m_idx);
        check("m_bcd",     int'(bcd_out),   e_bcd);
        check("m_blank",   int'(blank_out), int'(e_blank));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int v);
    load   = 1'b1;
    bin_in = BIN_W'(v);
    step(1);
    load   = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      step(1);
    end
  endtask

  int got_bcd[DIGITS];
  int got_blank[DIGITS];

  task automatic read_digits();
    for (int d = 0; d < DIGITS; d++) begin
      got_bcd[d] = -1;
      got_blank[d] = -1;
    end
    for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (dig_sel == DIGITS'(1 << d)) begin
          got_bcd[d]   = int'(bcd_out);
          got_blank[d] = int'(blank_out);
        end
      end
      step(1);
    end
  endtask

  task automatic expect_digits(input string tag, input int b0, input int b1,
                               input int b2, input int b3, input int k0,
                               input int k1, input int k2, input int k3);
    int eb[DIGITS];
    int ek[DIGITS];
    eb = '{b0, b1, b2, b3};
    ek = '{k0, k1, k2, k3};
    read_digits();
    for (int d = 0; d < DIGITS; d++) begin
      if (ek[d] == 0) check($sformatf("%s_bcd%0d", tag, d), got_bcd[d], eb[d]);
      check($sformatf("%s_blank%0d", tag, d), got_blank[d], ek[d]);
    end
  endtask

  task automatic load_and_settle(input int v);
    int cyc;
    do_load(v);
    wait_idle(cyc);
    check("settle_busy_len", cyc, BIN_W + 1);
    step(1);
  endtask

  int walk[5];
  int busy_cycles;

  initial begin
    walk = '{1, 2, 4, 8, 1};
    step(3);
    rst_n = 1'b1;

    // Reset state and idle walk of the digit select.
    check("rst_dig_sel", int'(dig_sel), 1);
    check("rst_bcd", int'(bcd_out), 0);
    check("rst_blank", int'(blank_out), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
    for (int k = 1; k < 5; k++) begin
      step(SCAN_DIV);
      check($sformatf("walk%0d", k), int'(dig_sel), walk[k]);
      check($sformatf("walk_blank%0d", k), int'(blank_out), 1);
    end

    // Full four-digit value and the busy window length.
    do_load(1234);
    check("busy_after_load", int'(busy), 1);
    wait_idle(busy_cycles);
    check("busy_len_1234", busy_cycles, 15);
    step(1);
    check("ovf_1234", int'(ovf), 0);
    expect_digits("v1234", 4, 3, 2, 1, 0, 0, 0, 0);

    // Leading-zero blanking, including the value zero.
    load_and_settle(7);
    expect_digits("v7", 7, 0, 0, 0, 0, 1, 1, 1);
    load_and_settle(0);
    expect_digits("v0", 0, 0, 0, 0, 0, 1, 1, 1);
    load_and_settle(10);
    expect_digits("v10", 0, 1, 0, 0, 0, 0, 1, 1);

    // Overflow saturates to nines; next load clears the flag.
    load_and_settle(12000);
    check("ovf_12000", int'(ovf), 1);
    expect_digits("v12000", 9, 9, 9, 9, 0, 0, 0, 0);
    load_and_settle(10000);
    check("ovf_10000", int'(ovf), 1);
    load_and_settle(9999);
    check("ovf_9999", int'(ovf), 0);
    expect_digits("v9999", 9, 9, 9, 9, 0, 0, 0, 0);
    load_and_settle(42);
    check("ovf_42", int'(ovf), 0);
    expect_digits("v42", 2, 4, 0, 0, 0, 0, 1, 1);

    // Load during conversion is dropped.
    do_load(1234);
    step(2);
    do_load(5678);
    wait_idle(busy_cycles);
    check("drop_busy_len", busy_cycles, 12);
    step(1);
    expect_digits("drop", 4, 3, 2, 1, 0, 0, 0, 0);

    // Reset in the middle of a conversion.
    do_load(9999);
    step(5);
    check("abort_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    step(1);
    check("abort_busy", int'(busy), 0);
    check("abort_dig_sel", int'(dig_sel), 1);
    check("abort_blank", int'(blank_out), 1);
    check("abort_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    expect_digits("abort", 0, 0, 0, 0, 1, 1, 1, 1);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
